hour_counter: RTL and testbench
===============================

# hour_counter

Hour stage of the digital clock, directly downstream of the minute stage. It consumes the minute stage's carry output (high while minutes wrap 59→00), counts hours 0–23, and accepts a debounced manual hour-advance key. It drives the two hour 7-segment digits (HEX7 tens, HEX6 units) in 24-hour or 12-hour format and emits a one-cycle day-carry pulse on the 23→00 wrap.

## Interface
- DEB_CYCLES, 50000: number of consecutive stable clock samples required before a key level is accepted.
- clock  input  1  system clock; all state is updated on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- min_carry  input  1  carry from the minute stage; asynchronous to clock, level signal; each rising edge means one hour.
- key_inc_n  input  1  manual hour-advance key, active-low, raw and bouncing.
- mode_12h  input  1  display format: 1 = 12-hour, 0 = 24-hour. Affects display only.
- hour_q  output  5  current hour, binary 0–23.
- pm  output  1  1 when hour_q ≥ 12; valid in both modes.
- day_carry  output  1  one-cycle pulse on an automatic 23→0 wrap.
- HEX7  output  7  tens digit, active-low segments {g,f,e,d,c,b,a}.
- HEX6  output  7  units digit, active-low segments.

## Operation
- Synchronisers: min_carry and key_inc_n each pass through two flops. Reset values are 0 for min_carry and 1 for the key.
- Carry edge: a third flop holds the previous synchronised min_carry. carry_rise = sync & ~prev.
- Debounce:
  - A counter compares the synchronised key level with the accepted level.
  - On mismatch it increments. When it reaches DEB_CYCLES-1, the accepted level flips and the counter clears.
  - On match the counter clears.
  - key_press is a one-cycle pulse when the accepted level goes 1→0. Release generates no event.
- Counting:
  - On carry_rise or key_press, hour_q becomes hour_q==23 ? 0 : hour_q+1.
  - If both occur in the same cycle, hour_q advances once only.
- day_carry is registered. It is 1 for exactly the cycle after hour_q wraps 23→0, and only when carry_rise caused the wrap. A key-caused wrap never produces day_carry.
- Display digits:
  - 24-hour mode: the displayed value is hour_q. HEX7 = tens (0–2), HEX6 = units. A leading 0 is shown.
  - 12-hour mode: hour_q 0 is shown as 12. hour_q 1–12 is shown unchanged. hour_q 13–23 is shown as hour_q−12.
  - 12-hour mode: a tens digit of 0 is blanked, so HEX7 = 7'b1111111.
- Binary→BCD uses the rule "tens = value≥20 ? 2 : value≥10 ? 1 : 0; units = value − 10·tens". The width is 5 bits throughout.
- Digits 0–9 use the standard active-low encoding, e.g. 0=7'b1000000, 1=7'b1111001, 2=7'b0100100.

## Timing
- Reset (asynchronous assert, synchronous to clock on release): hour_q=0, pm=0, day_carry=0, debounce counter=0, accepted key level=1.
- After reset, HEX7/HEX6 show "00" in 24-hour mode. In 12-hour mode they show blank/"2"… i.e. "12": HEX7=digit 1, HEX6=digit 2.
- Reset mid-debounce discards the pending press. Reset while min_carry is high does not generate an increment after release until min_carry falls and rises again.
- Carry latency: min_carry is sampled high at edge 1. carry_rise is true after edge 2. hour_q updates at edge 3.
- Key latency: hour_q updates DEB_CYCLES+3 edges after key_inc_n stably goes low, counting from the first sampling edge.
- HEX7, HEX6 and pm are combinational from hour_q and mode_12h. They change in the same cycle as hour_q, or immediately on a mode_12h change.
- A min_carry held high produces exactly one increment. Back-to-back rising edges need at least one low sample between them.

## Structure
- Shared package (clock_pkg): HOURS_MAX=23, SEG_BLANK=7'b1111111, and the digit-segment constants.
- Reuse the existing decoder0to9 twice (tens, units), with a blanking mux on HEX7.
- One natural new sub-module is key_debounce (synchroniser, counter, press pulse), reused later for the minute-set key.

## Test plan
- Reset with mode_12h=0 → hour_q=0, HEX7=HEX6=7'b1000000, day_carry=0. Switch mode_12h=1 → HEX7=digit 1, HEX6=digit 2, pm=0.
- Pulse min_carry 13 times (high 5 cycles, low 5 cycles) → hour_q=13, pm=1. 24-hour shows "13"; 12-hour shows blank + "1". Each update lands 3 edges after the rise.
- From hour_q=23, a min_carry rise → hour_q=0 and day_carry high exactly 1 cycle. From 23, key_press → hour_q=0 and day_carry stays 0.
- With DEB_CYCLES=4: bounce key_inc_n low/high every 2 cycles for 20 cycles, then hold low 10 cycles → exactly one increment; releasing gives none.
- key_press and carry_rise aligned in the same cycle at hour_q=5 → hour_q=6, not 7.
- Assert reset_n low while min_carry is high and hour_q=9, then release → hour_q=0 with no increment until min_carry toggles low→high.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the digital clock stages: hour limit and active-low
// 7-segment patterns, segment order {g,f,e,d,c,b,a}.
package clock_pkg;

    localparam logic [4:0] HOURS_MAX = 5'd23;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

endpackage

// File: rtl/decoder0to9.sv
// BCD digit to active-low 7-segment pattern; codes above 9 blank the digit.
module decoder0to9
    import clock_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// Active-low key conditioner: two-flop synchroniser, stability counter and a
// one-cycle registered pulse when the accepted level falls (press only).
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n_i,
    output logic press_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    // The level flips on the DEB_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = level_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/hour_counter.sv
// Hour stage: counts 0-23 on minute carry or debounced key, emits day carry on
// an automatic wrap and drives two hour digits in 24h or 12h format.
module hour_counter
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       min_carry,
    input  logic       key_inc_n,
    input  logic       mode_12h,
    output logic [4:0] hour_q,
    output logic       pm,
    output logic       day_carry,
    output logic [6:0] HEX7,
    output logic [6:0] HEX6
);

    logic       mc_sync1_q, mc_sync2_q, mc_prev_q;
    logic [1:0] fill_q;
    logic       carry_rise;
    logic       key_press;
    logic [4:0] hour_d;
    logic       day_carry_q, day_carry_d;
    logic [4:0] disp_val;
    logic [4:0] tens, units;
    logic [6:0] seg_tens;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n_i (key_inc_n),
        .press_o (key_press)
    );

    // prev is held high until the synchroniser has refilled after reset, so a
    // carry already high at reset release is not taken as a fresh rise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mc_sync1_q  <= 1'b0;
            mc_sync2_q  <= 1'b0;
            mc_prev_q   <= 1'b1;
            fill_q      <= 2'b00;
            hour_q      <= 5'd0;
            day_carry_q <= 1'b0;
        end else begin
            mc_sync1_q  <= min_carry;
            mc_sync2_q  <= mc_sync1_q;
            mc_prev_q   <= fill_q[1] ? mc_sync2_q : 1'b1;
            fill_q      <= {fill_q[0], 1'b1};
            hour_q      <= hour_d;
            day_carry_q <= day_carry_d;
        end
    end

    assign carry_rise = mc_sync2_q & ~mc_prev_q;

    always_comb begin
        hour_d      = hour_q;
        day_carry_d = 1'b0;
        if (carry_rise || key_press) begin
            hour_d = (hour_q == HOURS_MAX) ? 5'd0 : hour_q + 5'd1;
        end
        if (carry_rise && hour_q == HOURS_MAX) begin
            day_carry_d = 1'b1;
        end
    end

    assign day_carry = day_carry_q;
    assign pm        = (hour_q >= 5'd12);

    always_comb begin
        disp_val = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                disp_val = 5'd12;
            end else if (hour_q > 5'd12) begin
                disp_val = hour_q - 5'd12;
            end
        end
    end

    always_comb begin
        tens  = (disp_val >= 5'd20) ? 5'd2 : (disp_val >= 5'd10) ? 5'd1 : 5'd0;
        units = disp_val - ((tens == 5'd2) ? 5'd20 : (tens == 5'd1) ? 5'd10 : 5'd0);
    end

    decoder0to9 u_dec_tens (
        .digit_i (tens[3:0]),
        .seg_o   (seg_tens)
    );

    decoder0to9 u_dec_units (
        .digit_i (units[3:0]),
        .seg_o   (HEX6)
    );

    assign HEX7 = (mode_12h && tens == 5'd0) ? SEG_BLANK : seg_tens;

endmodule

// File: tb/tb_hour_counter.sv
// Directed bench for hour_counter with a short debounce window.
module tb_hour_counter;

    localparam int DEB = 4;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;

    logic       clock;
    logic       reset_n;
    logic       min_carry;
    logic       key_inc_n;
    logic       mode_12h;
    logic [4:0] hour_q;
    logic       pm;
    logic       day_carry;
    logic [6:0] HEX7;
    logic [6:0] HEX6;

    int n_cmp = 0;
    int n_err = 0;
    int dc_cnt;

    hour_counter #(.DEB_CYCLES(DEB)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .min_carry (min_carry),
        .key_inc_n (key_inc_n),
        .mode_12h  (mode_12h),
        .hour_q    (hour_q),
        .pm        (pm),
        .day_carry (day_carry),
        .HEX7      (HEX7),
        .HEX6      (HEX6)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic carry_pulse();
        min_carry = 1'b1;
        step(5);
        min_carry = 1'b0;
        step(5);
    endtask

    initial begin
        reset_n   = 1'b0;
        min_carry = 1'b0;
        key_inc_n = 1'b1;
        mode_12h  = 1'b0;
        #1;
        check("rst_hour", 32'(hour_q), 32'd0);
        check("rst_day_carry", 32'(day_carry), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(2);
        check("rst_hex7_24", 32'(HEX7), 32'(S0));
        check("rst_hex6_24", 32'(HEX6), 32'(S0));
        check("rst_pm", 32'(pm), 32'd0);
        mode_12h = 1'b1;
        #1;
        check("rst_hex7_12", 32'(HEX7), 32'(S1));
        check("rst_hex6_12", 32'(HEX6), 32'(S2));
        mode_12h = 1'b0;

        // carry latency: sampled at edge 1, hour moves at edge 3
        min_carry = 1'b1;
        step(2);
        check("carry_lat_e2", 32'(hour_q), 32'd0);
        step(1);
        check("carry_lat_e3", 32'(hour_q), 32'd1);
        step(2);
        min_carry = 1'b0;
        step(5);
        for (int i = 0; i < 12; i++) carry_pulse();
        check("hour_13", 32'(hour_q), 32'd13);
        check("pm_13", 32'(pm), 32'd1);
        check("hex7_13_24", 32'(HEX7), 32'(S1));
        check("hex6_13_24", 32'(HEX6), 32'(S3));
        mode_12h = 1'b1;
        #1;
        check("hex7_13_12", 32'(HEX7), 32'(S_BLANK));
        check("hex6_13_12", 32'(HEX6), 32'(S1));
        mode_12h = 1'b0;

        for (int i = 0; i < 10; i++) carry_pulse();
        check("hour_23", 32'(hour_q), 32'd23);

        // automatic wrap: day_carry for exactly one cycle
        dc_cnt = 0;
        min_carry = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            dc_cnt += int'(day_carry);
            if (i == 2) begin
                check("wrap_carry_hour", 32'(hour_q), 32'd0);
                check("wrap_carry_dc", 32'(day_carry), 32'd1);
            end
        end
        check("wrap_carry_dc_count", 32'(dc_cnt), 32'd1);
        min_carry = 1'b0;
        step(5);

        for (int i = 0; i < 23; i++) carry_pulse();
        check("hour_23_again", 32'(hour_q), 32'd23);

        // key wrap: DEB+3 edges latency, no day_carry
        dc_cnt = 0;
        key_inc_n = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            dc_cnt += int'(day_carry);
            if (i == 5) check("key_lat_e6", 32'(hour_q), 32'd23);
            if (i == 6) check("key_lat_e7", 32'(hour_q), 32'd0);
        end
        key_inc_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            dc_cnt += int'(day_carry);
        end
        check("key_wrap_no_dc", 32'(dc_cnt), 32'd0);
        check("key_release_none", 32'(hour_q), 32'd0);

        // bounce every 2 cycles, then a stable press and release
        for (int i = 0; i < 10; i++) begin
            key_inc_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            step(2);
        end
        check("bounce_none", 32'(hour_q), 32'd0);
        key_inc_n = 1'b0;
        step(10);
        check("bounce_press", 32'(hour_q), 32'd1);
        key_inc_n = 1'b1;
        step(10);
        check("bounce_release", 32'(hour_q), 32'd1);

        for (int i = 0; i < 4; i++) carry_pulse();
        check("hour_5", 32'(hour_q), 32'd5);

        // key_press and carry_rise land on the same edge
        key_inc_n = 1'b0;
        step(4);
        min_carry = 1'b1;
        step(10);
        check("coincident", 32'(hour_q), 32'd6);
        key_inc_n = 1'b1;
        min_carry = 1'b0;
        step(10);
        check("coincident_after", 32'(hour_q), 32'd6);

        // reset while min_carry is held high
        for (int i = 0; i < 2; i++) carry_pulse();
        min_carry = 1'b1;
        step(5);
        check("hour_9", 32'(hour_q), 32'd9);
        reset_n = 1'b0;
        #1;
        check("async_rst_hour", 32'(hour_q), 32'd0);
        step(2);
        reset_n = 1'b1;
        step(20);
        check("rst_carry_high", 32'(hour_q), 32'd0);
        min_carry = 1'b0;
        step(5);
        min_carry = 1'b1;
        step(5);
        check("rst_carry_retoggle", 32'(hour_q), 32'd1);
        min_carry = 1'b0;
        step(5);

        // reset mid-debounce discards the pending press
        key_inc_n = 1'b0;
        step(4);
        reset_n   = 1'b0;
        key_inc_n = 1'b1;
        step(2);
        reset_n = 1'b1;
        step(15);
        check("rst_mid_debounce", 32'(hour_q), 32'd0);

        mode_12h = 1'b1;
        #1;
        check("hex7_0_12", 32'(HEX7), 32'(S1));
        check("hex6_0_12", 32'(HEX6), 32'(S2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
